ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single-port data RAM between the CPU bus master (port 0) and the UART loader/debug master (port 1). It sits between both masters and the RAM, muxing address, data and write enable and routing read data back with a valid pulse. Round-robin fairness, a lock for atomic bursts, and a burst cap that prevents either master from starving the other.

## Interface
- DATA_WIDTH, 8, RAM data width.
- ADDR_WIDTH, 16, RAM address width.
- MAX_BURST, 4, maximum consecutive locked grants while the other port is requesting; 1..255.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_i[1:0]  in  2  per-port access request; bit 0 = CPU, bit 1 = UART loader.
- lock_i[1:0]  in  2  per-port lock; keeps the grant across consecutive accesses.
- we_i[1:0]  in  2  per-port write enable (1 = write, 0 = read).
- addr0_i, addr1_i  in  ADDR_WIDTH  per-port address.
- wdata0_i, wdata1_i  in  DATA_WIDTH  per-port write data.
- gnt_o[1:0]  out  2  one-hot-or-zero grant, combinational in the request cycle.
- rvalid_o[1:0]  out  2  registered one-cycle pulse: read data for that port is on rdata_o.
- rdata_o  out  DATA_WIDTH  RAM read data, shared by both ports and qualified by rvalid_o.
- ram_ce_o, ram_we_o  out  1  RAM chip enable and write enable.
- ram_addr_o  out  ADDR_WIDTH  RAM address.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_rdata_i  in  DATA_WIDTH  RAM synchronous read data, valid one cycle after the read.
- owner_o  out  2  status: {locked, last_granted_port}.

## Operation
- **State registers**
  - last: port granted most recently; reset 1, so port 0 wins the first contention.
  - lock_valid and lock_port: current lock owner, if any.
  - burst_cnt: 8-bit count of consecutive locked grants.
  - rd_pend[1:0]: read outstanding for each port.
- **Effective states:** IDLE (no lock_valid), LOCKED0, LOCKED1.
- **Grant rule, evaluated each cycle:**
  - A lock is honoured only when lock_valid, req_i[lock_port] and lock_i[lock_port] are all high, and either the other port is not requesting or burst_cnt < MAX_BURST. In that case only lock_port is granted.
  - Otherwise, with both ports requesting, grant the port != last.
  - Otherwise, grant whichever single port is requesting.
  - With no request, gnt_o = 0.
- **RAM signals:**
  - When a grant is issued: ram_ce_o = 1 and ram_we_o = we_i[g]; ram_addr_o and ram_wdata_o come from the granted port.
  - With no grant, ram_ce_o = 0, ram_we_o = 0, and address and data are driven to 0.
- **Updates on a granted cycle for port g:**
  - last <= g.
  - If lock_i[g] = 1: lock_port <= g and lock_valid <= 1. burst_cnt <= burst_cnt + 1 if g was already the lock owner, else 1.
  - If lock_i[g] = 0: lock_valid <= 0 and burst_cnt <= 0.
- **Forced release:** if the lock is refused because of the burst cap, lock_valid <= 0 and burst_cnt <= 0 on that cycle, and the other port is granted. The preempted port must re-acquire through normal round robin.
- **Lock drop:** lock_valid also clears on any cycle where the lock owner drops req_i or lock_i, with no grant to it.
- **Reads:** rd_pend[g] <= granted read. Next cycle rvalid_o = rd_pend and rdata_o = ram_rdata_i. Writes never produce rvalid.
- **Idle ports:** ports not granted hold their request. The arbiter never queues requests.

## Timing
- Grant is same-cycle combinational from req_i/lock_i plus registered state. There is no combinational path from gnt_o back to any input.
- One RAM access per cycle. Back-to-back grants to alternating ports are allowed, so throughput is 1 access/cycle.
- Read latency is exactly 1 cycle after the granted cycle. rvalid_o is a single-cycle pulse per read.
- Maximum wait for a requesting port is MAX_BURST + 1 cycles while the other port is locked, or 1 cycle with no lock.
- **Reset values:** gnt_o = 0, rvalid_o = 0, rdata_o = 0, ram_ce_o = 0, ram_we_o = 0, owner_o = 2'b01; all state registers cleared, except last = 1.
- **Reset mid-access:** an assertion during an outstanding read cancels it, so no rvalid is produced after release.
- Simultaneous lock_i from both ports with no current owner: round robin decides, and only the winner becomes owner.

## Test plan
- **Reset:** reset_n low with req_i = 2'b11 -> gnt_o = 0, ram_ce_o = 0, rvalid_o = 0. After release, the first contention grants port 0.
- **Contention, no lock:** both ports read addr0 = 0x0010 and addr1 = 0x0020 for 4 cycles -> grants alternate 01, 10, 01, 10. rvalid_o follows one cycle later with data preloaded at 0x10 and 0x20 (e.g. 0xF0 and 0x78).
- **Write/read-back via port 1:** write 0xA5 to 0x0100, then read 0x0100 -> rvalid_o = 2'b10 with rdata_o = 0xA5 on the cycle after the read grant.
- **Burst cap:** port 0 locked and continuously requesting, port 1 requesting, MAX_BURST = 4 -> port 0 granted 4 cycles, port 1 granted on the 5th, owner_o[1] = 0 after release.
- **Lock without contention:** port 0 locked with port 1 idle for 10 cycles -> 10 consecutive port 0 grants, no forced release.
- **Reset mid-read:** reset_n pulsed low in the cycle after a port 0 read grant -> no rvalid_o pulse.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the single-port data RAM.
// The slave modport is the arbiter's view; master is the masters' and RAM's view.
interface ram_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic [1:0]            req_i;
    logic [1:0]            lock_i;
    logic [1:0]            we_i;
    logic [ADDR_WIDTH-1:0] addr0_i;
    logic [ADDR_WIDTH-1:0] addr1_i;
    logic [DATA_WIDTH-1:0] wdata0_i;
    logic [DATA_WIDTH-1:0] wdata1_i;
    logic [1:0]            gnt_o;
    logic [1:0]            rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  ram_ce_o;
    logic                  ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;
    logic [1:0]            owner_o;

    modport slave (
        input  req_i, lock_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, ram_rdata_i,
        output gnt_o, rvalid_o, rdata_o, ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, owner_o
    );

    modport master (
        output req_i, lock_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, ram_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, owner_o
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the CPU (port 0) and
// the UART loader (port 1), with per-port lock and a burst cap against starvation.
module ram_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    ram_arbiter_if.slave  bus
);
    localparam logic [7:0] CAP = 8'(MAX_BURST);

    // lock_valid/lock_port are folded into the state encoding
    typedef enum logic [1:0] {IDLE, LOCKED0, LOCKED1} state_t;

    state_t     state, state_nxt;
    logic       last, last_nxt;
    logic [7:0] burst_cnt, burst_nxt;
    logic [1:0] rd_pend;
    logic [1:0] gnt;
    logic       locked, lp, owner_req, other_req, g;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
            rd_pend   <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
            rd_pend   <= gnt & ~bus.we_i;
        end
    end

    always_comb begin
        gnt       = '0;
        state_nxt = state;
        last_nxt  = last;
        burst_nxt = burst_cnt;
        locked    = (state != IDLE);
        lp        = (state == LOCKED1);
        owner_req = locked && bus.req_i[lp] && bus.lock_i[lp];
        other_req = bus.req_i[~lp];

        if (owner_req && (!other_req || burst_cnt < CAP))
            gnt[lp] = 1'b1;
        else if (owner_req)
            gnt[~lp] = 1'b1;            // burst cap hit: preempt the owner
        else if (bus.req_i == 2'b11)
            gnt[~last] = 1'b1;
        else
            gnt = bus.req_i;

        if (!reset_n)
            gnt = '0;

        g = gnt[1];
        if (|gnt) begin
            last_nxt = g;
            if (bus.lock_i[g]) begin
                state_nxt = g ? LOCKED1 : LOCKED0;
                if (locked && lp == g)
                    burst_nxt = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
                else
                    burst_nxt = 8'd1;
            end else begin
                state_nxt = IDLE;
                burst_nxt = '0;
            end
        end else if (locked) begin
            state_nxt = IDLE;
            burst_nxt = '0;
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.ram_ce_o    = |gnt;
    assign bus.ram_we_o    = |(gnt & bus.we_i);
    assign bus.ram_addr_o  = gnt[0] ? bus.addr0_i  : (gnt[1] ? bus.addr1_i  : '0);
    assign bus.ram_wdata_o = gnt[0] ? bus.wdata0_i : (gnt[1] ? bus.wdata1_i : '0);
    assign bus.rvalid_o    = rd_pend;
    assign bus.rdata_o     = (|rd_pend) ? bus.ram_rdata_i : '0;
    assign bus.owner_o     = {locked, last};
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: RAM model plus a queue of expected read returns.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MAX_BURST(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (!reset_n) begin
            ram[16'h0010] <= 8'hF0;
            ram[16'h0020] <= 8'h78;
        end else if (bus.ram_ce_o) begin
            if (bus.ram_we_o) ram[bus.ram_addr_o] <= bus.ram_wdata_o;
            else              bus.ram_rdata_i     <= ram[bus.ram_addr_o];
        end
    end

    typedef struct { logic [1:0] rv; logic [7:0] d; } exp_t;
    exp_t q[$];
    logic [7:0] exp_mem [logic [15:0]];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge: drive, check at the falling edge, advance.
    task automatic step(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] eg, input string tag);
        exp_t e, n;
        bus.req_i = req; bus.lock_i = lock; bus.we_i = we;
        bus.addr0_i = a0; bus.addr1_i = a1; bus.wdata0_i = d0; bus.wdata1_i = d1;
        @(negedge clk);
        if (q.size() > 0) e = q.pop_front();
        else begin e.rv = 2'b00; e.d = 8'h00; end
        chk({tag, ".rvalid"}, 32'(bus.rvalid_o), 32'(e.rv));
        if (e.rv != 2'b00) chk({tag, ".rdata"}, 32'(bus.rdata_o), 32'(e.d));
        chk({tag, ".gnt"}, 32'(bus.gnt_o), 32'(eg));
        chk({tag, ".ce"}, 32'(bus.ram_ce_o), 32'(|eg));
        if (eg != 2'b00) chk({tag, ".addr"}, 32'(bus.ram_addr_o), 32'(eg[0] ? a0 : a1));
        n.rv = eg & ~we;
        n.d  = n.rv[0] ? exp_mem[a0] : (n.rv[1] ? exp_mem[a1] : 8'h00);
        q.push_back(n);
        if (eg[0] && we[0]) exp_mem[a0] = d0;
        if (eg[1] && we[1]) exp_mem[a1] = d1;
        @(posedge clk); #1;
    endtask

    initial begin
        exp_mem[16'h0010] = 8'hF0;
        exp_mem[16'h0020] = 8'h78;
        bus.req_i = 2'b11; bus.lock_i = '0; bus.we_i = '0;
        bus.addr0_i = '0; bus.addr1_i = '0; bus.wdata0_i = '0; bus.wdata1_i = '0;

        // Reset with both ports requesting
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.gnt",    32'(bus.gnt_o),    32'h0);
        chk("rst.ce",     32'(bus.ram_ce_o), 32'h0);
        chk("rst.we",     32'(bus.ram_we_o), 32'h0);
        chk("rst.rvalid", 32'(bus.rvalid_o), 32'h0);
        chk("rst.rdata",  32'(bus.rdata_o),  32'h0);
        chk("rst.owner",  32'(bus.owner_o),  32'h1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Contention without lock: alternating grants starting with port 0
        step(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00, 2'b01, "rr0");
        step(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00, 2'b10, "rr1");
        step(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00, 2'b01, "rr2");
        step(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00, 2'b10, "rr3");
        step(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, "rr_idle");

        // Write then read back through port 1
        step(2'b10, 2'b00, 2'b10, 16'h0000, 16'h0100, 8'h00, 8'hA5, 2'b10, "p1_wr");
        chk("p1_wr.ram_we", 32'(ram[16'h0100]), 32'hA5);
        step(2'b10, 2'b00, 2'b00, 16'h0000, 16'h0100, 8'h00, 8'h00, 2'b10, "p1_rd");
        step(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, "p1_ret");

        // Burst cap: port 0 locked, port 1 requesting
        for (int unsigned i = 0; i < 4; i++)
            step(2'b11, 2'b01, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00, 2'b01, "burst_p0");
        step(2'b11, 2'b01, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00, 2'b10, "burst_p1");
        chk("burst.owner", 32'(bus.owner_o), 32'h1);
        step(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, "burst_idle");

        // Lock without contention: no forced release
        for (int unsigned i = 0; i < 10; i++)
            step(2'b01, 2'b01, 2'b00, 16'h0010, 16'h0000, 8'h00, 8'h00, 2'b01, "lock_solo");
        chk("lock_solo.owner", 32'(bus.owner_o), 32'h2);

        // Reset during an outstanding read cancels the return
        step(2'b01, 2'b00, 2'b00, 16'h0010, 16'h0000, 8'h00, 8'h00, 2'b01, "mid_rd");
        reset_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mid_rst.rvalid", 32'(bus.rvalid_o), 32'h0);
        chk("mid_rst.gnt",    32'(bus.gnt_o),    32'h0);
        chk("mid_rst.owner",  32'(bus.owner_o),  32'h1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, "post_rst");
        step(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h00, 8'h00, 2'b01, "post_rst_rr");
        step(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, "post_rst_ret");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
